dvp_sync_monitor: RTL and testbench
===================================

// Module: dvp_sync_monitor
// PURPOSE
//  Return-path checker for the camera clock: measures the DVP timing the sensor sends back (VSYNC/HREF).
//  Samples the sensor syncs in the ref_clk domain and reports line period, frame period and lines per frame.
//  Declares lock once frame timing is stable over consecutive frames; the HDMI side gates output on it.
// PARAMETERS
//  LINE_W        16  width of line-period counter/output (ref_clk cycles)
//  FRAME_W       22  width of frame-period counter/output (ref_clk cycles); saturation = sync-loss timeout
//  LINES_W       12  width of lines-per-frame counter/output
//  LINE_TOL      2   max |delta| line period between consecutive frames still counted as match
//  FRAME_TOL     64  max |delta| frame period between consecutive frames still counted as match
//  STABLE_FRAMES 4   consecutive matching frames required to assert locked (>=1)
// PORTS
//  ref_clk        in   1        system clock; sole clock
//  rst_n          in   1        async active-low reset
//  vsync_i        in   1        sensor VSYNC, asynchronous to ref_clk, active high
//  href_i         in   1        sensor HREF, asynchronous to ref_clk, active high
//  line_period    out  LINE_W   ref cycles between the last two HREF rises of the last frame
//  frame_period   out  FRAME_W  ref cycles between the last two VSYNC rises
//  lines_per_frame out LINES_W  HREF rises counted in the last frame
//  meas_valid     out  1        1-cycle pulse: the three measurement outputs were just updated
//  locked         out  1        timing stable
//  lost           out  1        1-cycle pulse: lock dropped (mismatch or timeout)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; all counters, match_cnt and the have_prev flag are 0. Async assert, sync release.
//  Input path: 2-FF sync per input, then registered rising-edge detect (vs_rise, hr_rise) at pin+3.
//  All outputs are registered; updates land at pin+4.
//  Counters:
//  - frame_cnt, line_cnt: +1 every cycle and saturate at all-ones.
//  - frame_cnt resets to 1 on vs_rise; line_cnt resets to 1 on hr_rise.
//  - line_cap: latched from line_cnt on hr_rise only if line_ok, i.e. a previous HREF rise occurred in the same frame.
//  - line_ok: cleared on vs_rise, set on hr_rise.
//  - lines_cnt: +1 on hr_rise (saturating), cleared on vs_rise.
//  Simultaneous vs_rise and hr_rise:
//  - vs_rise is processed first; the HREF rise becomes line 1 of the new frame (lines_cnt=1, line_ok=1).
//  - line_cap is not updated on that cycle.
//  Frame with no HREF, or only one: its line_period is reported as 0.
//  FSM states: IDLE, ACQUIRE, LOCKED.
//  - IDLE: counters held at 0. First vs_rise -> ACQUIRE (starts counting; no measurement output).
//  - ACQUIRE/LOCKED, on every vs_rise:
//    - publish frame_cnt, lines_cnt and line_cap (0 if the frame had <2 HREF rises); pulse meas_valid.
//    - compare against the previous published set. Match = lines equal AND |dLine|<=LINE_TOL AND |dFrame|<=FRAME_TOL.
//    - differences are computed in width+1 bits, absolute value.
//    - first published frame after IDLE has no previous set (have_prev=0), so it is a mismatch.
//  - ACQUIRE: match -> match_cnt+1 (saturating at STABLE_FRAMES); mismatch -> match_cnt=0.
//    When match_cnt reaches STABLE_FRAMES -> LOCKED; locked=1 in the same cycle as meas_valid.
//  - LOCKED: mismatch -> ACQUIRE, match_cnt=0, locked=0, lost=1 (all with meas_valid).
//  - Timeout, any non-IDLE state: frame_cnt saturates -> IDLE; locked=0; have_prev=0; match_cnt=0.
//    lost pulses only if leaving LOCKED. Measurement outputs hold their last values; no meas_valid.
//  Reset mid-operation: immediate return to reset values regardless of state.
// TESTING (LINE_W=12, FRAME_W=12, LINES_W=8, LINE_TOL=2, FRAME_TOL=8, STABLE_FRAMES=4)
//  1 Reset with inputs toggling -> all outputs 0, no meas_valid until a second VSYNC rise after release.
//  2 HREF period 100, 10 lines, VSYNC period 1500, pulses 1 cycle apart:
//    - meas_valid 4 cycles after each VSYNC pin rise from the 2nd onward, with line_period=100, lines_per_frame=10, frame_period=1500.
//    - locked rises with the 6th rise's meas_valid.
//  3 Locked; line period alternates 100/101 and frame 1500/1505 -> locked stays 1, lost never pulses.
//  4 Locked; one frame with 11 lines:
//    - that frame's meas_valid comes with lost=1 and locked=0.
//    - the next frame (back to 10 lines) is also a mismatch.
//    - locked returns 4 matching frames after that.
//  5 Locked; VSYNC held low -> lost=1, locked=0 once frame_cnt reaches 4095; outputs still 100/10/1500; FSM back in IDLE.
//  6 VSYNC and HREF rise on the same cycle -> next frame's lines_per_frame counts that HREF (10).
//    Reset asserted mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/dvp_sync_monitor_if.sv
// DVP sync-monitor bus: sensor sync inputs plus the measured timing and lock status.
interface dvp_sync_monitor_if #(
    parameter int LINE_W  = 16,
    parameter int FRAME_W = 22,
    parameter int LINES_W = 12
);
    logic               vsync_i;
    logic               href_i;
    logic [LINE_W-1:0]  line_period;
    logic [FRAME_W-1:0] frame_period;
    logic [LINES_W-1:0] lines_per_frame;
    logic               meas_valid;
    logic               locked;
    logic               lost;

    modport master (
        output vsync_i, href_i,
        input  line_period, frame_period, lines_per_frame, meas_valid, locked, lost
    );

    modport slave (
        input  vsync_i, href_i,
        output line_period, frame_period, lines_per_frame, meas_valid, locked, lost
    );
endinterface

// File: rtl/dvp_sync_monitor.sv
// Measures sensor VSYNC/HREF timing in the ref_clk domain and declares lock once
// consecutive frames agree within tolerance; drops lock on mismatch or sync-loss timeout.
module dvp_sync_monitor #(
    parameter int LINE_W        = 16,
    parameter int FRAME_W       = 22,
    parameter int LINES_W       = 12,
    parameter int LINE_TOL      = 2,
    parameter int FRAME_TOL     = 64,
    parameter int STABLE_FRAMES = 4
) (
    input  logic            ref_clk,
    input  logic            rst_n,
    dvp_sync_monitor_if.slave dvp
);
    localparam int              MC_W   = $clog2(STABLE_FRAMES + 1);
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(STABLE_FRAMES);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    state_t             state_q, state_d;
    logic               rst_meta_n, rst_sync_n;
    logic [2:0]         vs_sh, hr_sh;
    logic               vs_rise, hr_rise;
    logic [FRAME_W-1:0] frame_cnt;
    logic [LINE_W-1:0]  line_cnt, line_cap;
    logic [LINES_W-1:0] lines_cnt;
    logic               line_ok;
    logic [MC_W-1:0]    match_cnt, mc_d;
    logic               have_prev, have_prev_d;
    logic               publish, lost_d, run;
    logic [LINE_W-1:0]  line_period_q, pub_line;
    logic [FRAME_W-1:0] frame_period_q;
    logic [LINES_W-1:0] lines_q;
    logic               meas_valid_q, locked_q, lost_q;
    logic [LINE_W:0]    line_diff, line_abs;
    logic [FRAME_W:0]   frame_diff, frame_abs;
    logic               is_match;

    // Reset asserts asynchronously but releases on a ref_clk edge.
    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    always_ff @(posedge ref_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            vs_sh   <= '0;
            hr_sh   <= '0;
            vs_rise <= 1'b0;
            hr_rise <= 1'b0;
        end else begin
            vs_sh   <= {vs_sh[1:0], dvp.vsync_i};
            hr_sh   <= {hr_sh[1:0], dvp.href_i};
            vs_rise <= vs_sh[1] & ~vs_sh[2];
            hr_rise <= hr_sh[1] & ~hr_sh[2];
        end
    end

    // line_cap is only fresh for this frame once a second HREF rise has been seen.
    assign pub_line   = (lines_cnt >= LINES_W'(2)) ? line_cap : '0;
    assign line_diff  = {1'b0, pub_line} - {1'b0, line_period_q};
    assign line_abs   = line_diff[LINE_W] ? -line_diff : line_diff;
    assign frame_diff = {1'b0, frame_cnt} - {1'b0, frame_period_q};
    assign frame_abs  = frame_diff[FRAME_W] ? -frame_diff : frame_diff;
    assign is_match   = have_prev && (lines_cnt == lines_q)
                        && (line_abs <= (LINE_W + 1)'(LINE_TOL))
                        && (frame_abs <= (FRAME_W + 1)'(FRAME_TOL));

    always_ff @(posedge ref_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q   <= IDLE;
            match_cnt <= '0;
            have_prev <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_cnt <= mc_d;
            have_prev <= have_prev_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mc_d        = match_cnt;
        have_prev_d = have_prev;
        publish     = 1'b0;
        lost_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (vs_rise) state_d = ACQUIRE;
            end
            ACQUIRE, LOCKED: begin
                if (vs_rise) begin
                    publish     = 1'b1;
                    have_prev_d = 1'b1;
                    if (is_match) begin
                        mc_d = (match_cnt == MC_MAX) ? match_cnt : match_cnt + 1'b1;
                        if (mc_d == MC_MAX) state_d = LOCKED;
                    end else begin
                        mc_d    = '0;
                        state_d = ACQUIRE;
                        lost_d  = (state_q == LOCKED);
                    end
                end else if (&frame_cnt) begin
                    state_d     = IDLE;
                    mc_d        = '0;
                    have_prev_d = 1'b0;
                    lost_d      = (state_q == LOCKED);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_d != IDLE);

    // vs_rise wins over a coincident hr_rise: that HREF becomes line 1 of the new frame.
    always_ff @(posedge ref_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            frame_cnt <= '0;
            line_cnt  <= '0;
            lines_cnt <= '0;
            line_ok   <= 1'b0;
            line_cap  <= '0;
        end else if (!run) begin
            frame_cnt <= '0;
            line_cnt  <= '0;
            lines_cnt <= '0;
            line_ok   <= 1'b0;
        end else begin
            frame_cnt <= vs_rise ? FRAME_W'(1) : ((&frame_cnt) ? frame_cnt : frame_cnt + 1'b1);
            line_cnt  <= hr_rise ? LINE_W'(1) : ((&line_cnt) ? line_cnt : line_cnt + 1'b1);
            if (vs_rise) begin
                lines_cnt <= hr_rise ? LINES_W'(1) : '0;
                line_ok   <= hr_rise;
            end else if (hr_rise) begin
                lines_cnt <= (&lines_cnt) ? lines_cnt : lines_cnt + 1'b1;
                line_ok   <= 1'b1;
                if (line_ok) line_cap <= line_cnt;
            end
        end
    end

    always_ff @(posedge ref_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            line_period_q  <= '0;
            frame_period_q <= '0;
            lines_q        <= '0;
            meas_valid_q   <= 1'b0;
            locked_q       <= 1'b0;
            lost_q         <= 1'b0;
        end else begin
            meas_valid_q <= publish;
            locked_q     <= (state_d == LOCKED);
            lost_q       <= lost_d;
            if (publish) begin
                line_period_q  <= pub_line;
                frame_period_q <= frame_cnt;
                lines_q        <= lines_cnt;
            end
        end
    end

    assign dvp.line_period     = line_period_q;
    assign dvp.frame_period    = frame_period_q;
    assign dvp.lines_per_frame = lines_q;
    assign dvp.meas_valid      = meas_valid_q;
    assign dvp.locked          = locked_q;
    assign dvp.lost            = lost_q;
endmodule

// File: tb/tb_dvp_sync_monitor.sv
// Directed bench for dvp_sync_monitor: a pin-level timing model pushes expected
// measurement/lock events to a scoreboard that is checked when the DUT responds.
module tb_dvp_sync_monitor;
    localparam int LW = 12, FW = 12, NW = 8;
    localparam int FRAME_MAX = 4095;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    dvp_sync_monitor_if #(.LINE_W(LW), .FRAME_W(FW), .LINES_W(NW)) bus ();

    dvp_sync_monitor #(
        .LINE_W(LW), .FRAME_W(FW), .LINES_W(NW),
        .LINE_TOL(2), .FRAME_TOL(8), .STABLE_FRAMES(4)
    ) dut (
        .ref_clk(clk),
        .rst_n  (rst_n),
        .dvp    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit mv;
        bit lost;
        bit locked;
        int line;
        int frame;
        int lines;
    } ev_t;
    ev_t sb[$];

    // model state: timestamps of pin-level edges
    bit m_act, m_have_prev, m_locked, vs_prev, hr_prev;
    int m_last_vs, m_hr_n, m_hr_last, m_line_p, m_mc;
    int p_line, p_frame, p_lines;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        m_act = 0; m_have_prev = 0; m_locked = 0; m_mc = 0;
        m_hr_n = 0; m_line_p = 0; vs_prev = 0; hr_prev = 0;
        p_line = 0; p_frame = 0; p_lines = 0;
    endtask

    task automatic model(input bit vsr, input bit hrr, input int k);
        ev_t e;
        int  f, l, n;
        bit  match;
        if (!m_act) begin
            if (vsr) begin
                m_act = 1; m_last_vs = k; m_hr_n = hrr ? 1 : 0; m_hr_last = k;
            end
        end else if (vsr) begin
            f = k - m_last_vs;
            l = (m_hr_n >= 2) ? m_line_p : 0;
            n = m_hr_n;
            match = m_have_prev && (n == p_lines) && (iabs(l - p_line) <= 2) && (iabs(f - p_frame) <= 8);
            e.lost = 0;
            if (m_locked) begin
                if (!match) begin m_locked = 0; m_mc = 0; e.lost = 1; end
            end else if (match) begin
                m_mc++;
                if (m_mc >= 4) m_locked = 1;
            end else begin
                m_mc = 0;
            end
            e.cyc = k + LAT; e.mv = 1; e.locked = m_locked;
            e.line = l; e.frame = f; e.lines = n;
            sb.push_back(e);
            p_line = l; p_frame = f; p_lines = n; m_have_prev = 1;
            m_last_vs = k; m_hr_n = hrr ? 1 : 0; m_hr_last = k;
        end else if (k - m_last_vs == FRAME_MAX) begin
            e.cyc = k + LAT; e.mv = 0; e.lost = m_locked; e.locked = 0;
            e.line = p_line; e.frame = p_frame; e.lines = p_lines;
            sb.push_back(e);
            m_act = 0; m_have_prev = 0; m_mc = 0; m_locked = 0;
        end else if (hrr) begin
            if (m_hr_n >= 1) m_line_p = k - m_hr_last;
            if (m_hr_n < 255) m_hr_n++;
            m_hr_last = k;
        end
    endtask

    task automatic step(input bit vs, input bit hr);
        @(negedge clk);
        bus.vsync_i = vs;
        bus.href_i  = hr;
        model(vs && !vs_prev, hr && !hr_prev, cyc);
        vs_prev = vs;
        hr_prev = hr;
    endtask

    task automatic frame(input int fper, input int nlines, input int lper, input int off);
        for (int t = 0; t < fper; t++)
            step(t == 0, (t >= off) && ((t - off) % lper == 0) && ((t - off) / lper < nlines));
    endtask

    task automatic chk_outputs(input string tag, input int line, input int frm, input int lines);
        chk({tag, "_line_period"}, bus.line_period, line);
        chk({tag, "_frame_period"}, bus.frame_period, frm);
        chk({tag, "_lines_per_frame"}, bus.lines_per_frame, lines);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                ev_t e;
                e = sb.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("meas_valid", bus.meas_valid, e.mv);
                chk("lost", bus.lost, e.lost);
                chk("locked", bus.locked, e.locked);
                chk_outputs("ev", e.line, e.frame, e.lines);
            end else if (bus.meas_valid || bus.lost) begin
                chk("spurious_pulse", {bus.meas_valid, bus.lost}, 0);
            end
        end
    end

    initial begin
        bus.vsync_i = 0;
        bus.href_i  = 0;
        model_reset();

        // 1: reset held with inputs toggling
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.vsync_i = i[0];
            bus.href_i  = i[1];
        end
        chk_outputs("reset", 0, 0, 0);
        chk("reset_meas_valid", bus.meas_valid, 0);
        chk("reset_locked", bus.locked, 0);
        chk("reset_lost", bus.lost, 0);
        @(negedge clk);
        bus.vsync_i = 0;
        bus.href_i  = 0;
        @(negedge clk);
        rst_n = 1;
        model_reset();
        mon_en = 1;
        repeat (10) step(0, 0);

        // 2: nominal 100/10/1500 timing until lock
        repeat (5) frame(1500, 10, 100, 20);
        chk("not_locked_after_5th", bus.locked, 0);
        frame(1500, 10, 100, 20);
        chk("locked_after_6th", bus.locked, 1);
        chk_outputs("nominal", 100, 1500, 10);

        // 3: jitter within tolerance
        repeat (3) begin
            frame(1505, 10, 101, 20);
            frame(1500, 10, 100, 20);
        end
        chk("locked_through_jitter", bus.locked, 1);

        // 4: one 11-line frame breaks lock, then re-acquire
        frame(1500, 11, 100, 20);
        frame(1500, 10, 100, 20);
        chk("lost_lock_11_lines", bus.locked, 0);
        chk("lines_11", bus.lines_per_frame, 11);
        repeat (4) frame(1500, 10, 100, 20);
        frame(1000, 10, 100, 20);
        chk("relocked", bus.locked, 1);

        // 5: VSYNC held low -> timeout
        repeat (3200) step(0, 0);
        chk("timeout_unlocked", bus.locked, 0);
        chk_outputs("timeout_hold", 100, 1500, 10);

        // 6: coincident VSYNC/HREF rises, then async reset mid-frame
        frame(1500, 10, 100, 0);
        frame(1500, 10, 100, 0);
        frame(300, 3, 100, 0);
        chk_outputs("coincident", 100, 1500, 10);
        chk("sb_drained", sb.size(), 0);
        mon_en = 0;
        #2 rst_n = 0;
        #1;
        chk_outputs("async_reset", 0, 0, 0);
        chk("async_reset_locked", bus.locked, 0);
        chk("async_reset_meas_valid", bus.meas_valid, 0);
        sb.delete();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
